// File: rtl/ext_pipe.sv
// Immediate / load-data extension unit with a 2-entry output buffer.
// The result is computed when an entry is accepted, and entries leave in order.
module ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int OFF_W = $clog2(OUT_W / 8)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OUT_W-1:0] in_data,
  input  logic [OFF_W-1:0] in_off,
  input  logic [3:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
);

  // Returns {result, err}; error entries always carry a zero result.
  function automatic logic [OUT_W:0] extend(input logic [OUT_W-1:0] d,
                                            input logic [OFF_W-1:0] off,
                                            input logic [3:0]       mode);
    logic [OUT_W-1:0] zx, sx, lane, bzx, bsx, hzx, hsx, res;
    logic             err;
    zx            = {OUT_W{1'b0}};
    zx[IN_W-1:0]  = d[IN_W-1:0];
    sx            = {OUT_W{d[IN_W-1]}};
    sx[IN_W-1:0]  = d[IN_W-1:0];
    lane          = d >> {off, 3'b000};
    bzx           = {OUT_W{1'b0}};
    bzx[7:0]      = lane[7:0];
    bsx           = {OUT_W{lane[7]}};
    bsx[7:0]      = lane[7:0];
    hzx           = {OUT_W{1'b0}};
    hzx[15:0]     = lane[15:0];
    hsx           = {OUT_W{lane[15]}};
    hsx[15:0]     = lane[15:0];
    res           = {OUT_W{1'b0}};
    err           = 1'b0;
    case (mode)
      4'd0: res = zx;
      4'd1: res = sx;
      4'd2: res = zx << (OUT_W - IN_W);
      4'd3: res = sx << 2;
      4'd4: res = bsx;
      4'd5: res = bzx;
      4'd6: begin
        if (off[0]) begin
          err = 1'b1;
        end else begin
          res = hsx;
        end
      end
      4'd7: begin
        if (off[0]) begin
          err = 1'b1;
        end else begin
          res = hzx;
        end
      end
      default: err = 1'b1;
    endcase
    return {res, err};
  endfunction

  logic [1:0]     cnt_q, cnt_d;
  logic [OUT_W:0] e0_q, e0_d, e1_q, e1_d;
  logic [OUT_W:0] new_s;
  logic           push_s, pop_s;

  assign in_ready  = reset_n & (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign push_s    = in_valid & in_ready & ~flush;
  assign pop_s     = out_valid & out_ready & ~flush;
  assign new_s     = extend(in_data, in_off, in_mode);
  assign out_data  = out_valid ? e0_q[OUT_W:1] : {OUT_W{1'b0}};
  assign out_err   = out_valid ? e0_q[0] : 1'b0;

  // Buffer next state: e0 is always the head entry, e1 the one behind it.
  always_comb begin
    cnt_d = cnt_q;
    e0_d  = e0_q;
    e1_d  = e1_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case (cnt_q)
        2'd0: begin
          if (push_s) begin
            e0_d  = new_s;
            cnt_d = 2'd1;
          end else begin
            cnt_d = 2'd0;
          end
        end
        2'd1: begin
          if (push_s && pop_s) begin
            e0_d = new_s;
          end else if (push_s) begin
            e1_d  = new_s;
            cnt_d = 2'd2;
          end else if (pop_s) begin
            cnt_d = 2'd0;
          end else begin
            cnt_d = 2'd1;
          end
        end
        2'd2: begin
          if (pop_s) begin
            e0_d  = e1_q;
            cnt_d = 2'd1;
          end else begin
            cnt_d = 2'd2;
          end
        end
        default: cnt_d = 2'd0;
      endcase
    end
  end

  // State registers; reset clears occupancy and storage and overrides flush.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= 2'd0;
      e0_q  <= {(OUT_W + 1){1'b0}};
      e1_q  <= {(OUT_W + 1){1'b0}};
    end else begin
      cnt_q <= cnt_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: queue-based reference model compared every
// cycle, plus directed literal checks for the documented example values.
module tb_ext_pipe;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic [1:0]  in_off = 2'd0;
  logic [3:0]  in_mode = 4'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_err;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  logic [32:0] model_q[$];

  ext_pipe dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_off(in_off), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] ref_ext(logic [31:0] d, logic [1:0] off, logic [3:0] m);
    logic [15:0] imm;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] t;
    int          lane;
    imm  = d[15:0];
    lane = int'(off);
    b    = d[lane*8 +: 8];
    h    = (lane <= 2) ? d[lane*8 +: 16] : 16'h0;
    case (m)
      4'd0: t = 32'(imm);
      4'd1: t = 32'($signed(imm));
      4'd2: t = {imm, 16'h0000};
      4'd3: t = 32'($signed(imm)) * 32'd4;
      4'd4: t = 32'($signed(b));
      4'd5: t = 32'(b);
      4'd6: begin
        if (off[0]) return {32'h0, 1'b1};
        t = 32'($signed(h));
      end
      4'd7: begin
        if (off[0]) return {32'h0, 1'b1};
        t = 32'(h);
      end
      default: return {32'h0, 1'b1};
    endcase
    return {t, 1'b0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the reference model by one clock edge using the inputs present at it.
  task automatic model_step();
    bit push, pop;
    if (!reset_n) begin
      model_q.delete();
    end else if (flush) begin
      model_q.delete();
    end else begin
      push = in_valid && (model_q.size() < 2);
      pop  = (model_q.size() > 0) && out_ready;
      if (pop) void'(model_q.pop_front());
      if (push) model_q.push_back(ref_ext(in_data, in_off, in_mode));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    chk_en = 1'b1;
    #1;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        logic [32:0] head;
        head = (model_q.size() > 0) ? model_q[0] : 33'h0;
        chk("in_ready", 64'(in_ready), 64'(reset_n && (model_q.size() < 2)));
        chk("out_valid", 64'(out_valid), 64'(model_q.size() > 0));
        chk("out_data", 64'(out_data), 64'(head[32:1]));
        chk("out_err", 64'(out_err), 64'(head[0]));
      end
    end
  end

  task automatic push_one(input string name, input logic [3:0] m, input logic [31:0] d,
                          input logic [1:0] off, input logic [31:0] exp_d, input logic exp_e);
    in_valid = 1'b1; in_mode = m; in_data = d; in_off = off; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_data"}, 64'(out_data), 64'(exp_d));
    chk({name, "_err"}, 64'(out_err), 64'(exp_e));
    cycle();
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) cycle();
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    reset_n = 1'b1;
    cycle();
    @(negedge clk);
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    push_one("m0", 4'd0, 32'h00008001, 2'd0, 32'h00008001, 1'b0);
    push_one("m1", 4'd1, 32'h00008001, 2'd0, 32'hFFFF8001, 1'b0);
    push_one("m2", 4'd2, 32'h00008001, 2'd0, 32'h80010000, 1'b0);
    push_one("m3", 4'd3, 32'h00008001, 2'd0, 32'hFFFE0004, 1'b0);
    push_one("lb", 4'd4, 32'h12F45678, 2'd2, 32'hFFFFFFF4, 1'b0);
    push_one("lbu", 4'd5, 32'h12F45678, 2'd2, 32'h000000F4, 1'b0);
    push_one("lh", 4'd6, 32'h12F45678, 2'd2, 32'h000012F4, 1'b0);
    push_one("lhu", 4'd7, 32'h12F45678, 2'd0, 32'h00005678, 1'b0);
    push_one("lh_mis", 4'd6, 32'h12F45678, 2'd1, 32'h00000000, 1'b1);
    push_one("ill", 4'd9, 32'h12F45678, 2'd0, 32'h00000000, 1'b1);

    // Backpressure: A and B fill the buffer, C waits.
    in_mode = 4'd0; in_off = 2'd0; out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h0000000A; cycle();
    in_data = 32'h0000000B; cycle();
    @(negedge clk);
    chk("bp_full_ready", 64'(in_ready), 64'd0);
    in_data = 32'h0000000C; cycle();
    @(negedge clk);
    chk("bp_hold_ready", 64'(in_ready), 64'd0);
    chk("bp_hold_a", 64'(out_data), 64'h0A);
    out_ready = 1'b1; cycle();
    @(negedge clk);
    chk("bp_b", 64'(out_data), 64'h0B);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_c", 64'(out_data), 64'h0C);
    cycle();
    @(negedge clk);
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Streaming at full rate.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 32'(i + 16);
      cycle();
      @(negedge clk);
      chk("stream_data", 64'(out_data), 64'(i + 16));
      chk("stream_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0; cycle();

    // Flush a full buffer with a concurrent push.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'h000000D0; cycle();
    in_data = 32'h000000E0; cycle();
    flush = 1'b1; in_data = 32'h000000F0; cycle();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    cycle();

    // Reset while one entry is buffered.
    in_valid = 1'b1; in_data = 32'h00000077; cycle();
    in_valid = 1'b0; reset_n = 1'b0; cycle();
    @(negedge clk);
    chk("mrst_ready", 64'(in_ready), 64'd0);
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_data", 64'(out_data), 64'd0);
    reset_n = 1'b1; in_valid = 1'b1; in_data = 32'h00000099; cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("mrst_first", 64'(out_data), 64'h99);
    out_ready = 1'b1; cycle();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      reset_n   = ($urandom_range(0, 99) != 0);
      in_mode   = 4'($urandom_range(0, 15));
      in_off    = 2'($urandom_range(0, 3));
      in_data   = $urandom;
      cycle();
    end
    reset_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
    repeat (3) cycle();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
